pll_phase_stepper: RTL and testbench



---
 rtl/pll_phase_pkg.sv | 24 ++
 rtl/pll_phase_timer.sv | 34 +++
 rtl/pll_phase_stepper.sv | 181 ++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types and defaults for the ECP5 EHXPLLL dynamic phase-adjust controller.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_GAP_CYCLES   = 4;

  // Wide enough for any realistic SETUP/PULSE/GAP duration.
  localparam int TIMER_W = 16;

endpackage

// File: rtl/pll_phase_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded duration.
module pll_phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         running;

  // Loading N makes expire rise in the Nth cycle after the load edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= cycles - W'(1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives the EHXPLLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG pins from step/reload
// requests and keeps a signed step offset for each of the four PLL outputs.
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int COUNT_W      = 8,
  parameter int POS_W        = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [COUNT_W-1:0] req_count,
  input  logic               req_load,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  input  logic [1:0]         rd_sel,
  output logic [POS_W-1:0]   rd_pos,
  output state_t             dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; the requester holds req_* stable while req_valid waits for ready.

  localparam logic [TIMER_W-1:0] T_SETUP = TIMER_W'(SETUP_CYCLES);
  localparam logic [TIMER_W-1:0] T_PULSE = TIMER_W'(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] T_GAP   = TIMER_W'(GAP_CYCLES);

  state_t               state;
  state_t               next_state;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_cycles;
  logic                 timer_expire;
  logic                 accept;
  logic                 skip;
  logic                 live;
  logic                 abort;
  logic                 strobe_end;
  logic                 load_q;
  logic [COUNT_W-1:0]   remaining;
  logic [POS_W-1:0]     pos [4];

  assign accept     = req_valid && req_ready;
  assign skip       = (req_count == '0) && !req_load;
  assign live       = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_GAP);
  assign abort      = live && !locked;
  assign strobe_end = (state == ST_STROBE) && timer_expire && locked;

  pll_phase_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .cycles  (timer_cycles),
    .expire  (timer_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    timer_load   = 1'b0;
    timer_cycles = T_SETUP;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (skip) begin
            next_state = ST_FINISH;
          end else begin
            next_state   = ST_SETUP;
            timer_load   = 1'b1;
            timer_cycles = T_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (!locked) begin
          next_state = ST_IDLE;
        end else if (timer_expire) begin
          next_state   = ST_STROBE;
          timer_load   = 1'b1;
          timer_cycles = T_PULSE;
        end
      end
      ST_STROBE: begin
        if (!locked) begin
          next_state = ST_IDLE;
        end else if (timer_expire) begin
          next_state   = ST_GAP;
          timer_load   = 1'b1;
          timer_cycles = T_GAP;
        end
      end
      ST_GAP: begin
        if (!locked) begin
          next_state = ST_IDLE;
        end else if (timer_expire) begin
          if (remaining != '0) begin
            next_state   = ST_STROBE;
            timer_load   = 1'b1;
            timer_cycles = T_PULSE;
          end else begin
            next_state = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register, so a lock-loss edge releases them.
  always_comb begin
    req_ready    = (state == ST_IDLE) && locked && reset_n;
    busy         = (state != ST_IDLE);
    done         = (state == ST_FINISH);
    phasestep    = !((state == ST_STROBE) && !load_q);
    phaseloadreg = !((state == ST_STROBE) && load_q);
  end

  assign dbg_state = state;

  // A zero-count request leaves the phase pins untouched since no strobe follows.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phasesel  <= SEL_CLKOP;
      phasedir  <= 1'b0;
      load_q    <= 1'b0;
      remaining <= '0;
      aborted   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos[i] <= '0;
      end
    end else begin
      aborted <= abort;
      if (accept) begin
        load_q    <= req_load;
        remaining <= req_load ? COUNT_W'(1) : req_count;
        if (!skip) begin
          phasesel <= req_sel;
          phasedir <= req_dir;
        end
      end
      if (strobe_end) begin
        remaining <= remaining - COUNT_W'(1);
        if (load_q) begin
          pos[phasesel] <= '0;
        end else if (phasedir) begin
          pos[phasesel] <= pos[phasesel] - POS_W'(1);
        end else begin
          pos[phasesel] <= pos[phasesel] + POS_W'(1);
        end
      end
    end
  end

  assign rd_pos = pos[rd_sel];

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Randomised scoreboard bench for pll_phase_stepper: per-request expectations are
// queued by the driver and matched by a monitor on every done/aborted pulse.
module tb_pll_phase_stepper;
  import pll_phase_pkg::*;

  localparam int S       = 2;
  localparam int P       = 4;
  localparam int G       = 4;
  localparam int COUNT_W = 8;
  localparam int POS_W   = 8;

  typedef struct packed {
    logic              aborted;
    logic [15:0]       lat;
    logic [15:0]       step_low;
    logic [15:0]       load_low;
    logic [1:0]        sel;
    logic              dir;
    logic [4*POS_W-1:0] pos;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               locked = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_sel = 2'd0;
  logic               req_dir = 1'b0;
  logic [COUNT_W-1:0] req_count = '0;
  logic               req_load = 1'b0;
  logic [1:0]         phasesel;
  logic               phasedir;
  logic               phasestep;
  logic               phaseloadreg;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [1:0]         rd_sel = 2'd0;
  logic [POS_W-1:0]   rd_pos;
  state_t             dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int               model_pos[4];
  int               n_cmp = 0;
  int               n_err = 0;
  int               n_done = 0;
  int               cyc = 0;
  int               acc_cyc = 0;
  int               step_low = 0;
  int               load_low = 0;
  bit               tracking = 0;

  pll_phase_stepper #(
    .SETUP_CYCLES (S),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .COUNT_W      (COUNT_W),
    .POS_W        (POS_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .locked       (locked),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_count    (req_count),
    .req_load     (req_load),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .rd_sel       (rd_sel),
    .rd_pos       (rd_pos),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: positions are plain integers reduced modulo 2^POS_W
  task automatic model_steps(input int sel, input bit dir, input int n);
    int m;
    m = 1 << POS_W;
    model_pos[sel] = (((model_pos[sel] + (dir ? -n : n)) % m) + m) % m;
  endtask

  // Monitor: observes acceptance, strobe activity and completion pulses
  always @(negedge clock) begin
    exp_t cur;
    if (!reset_n) begin
      tracking = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc  = cyc;
        step_low = 0;
        load_low = 0;
        tracking = 1;
      end else if (tracking) begin
        if (!phasestep) step_low++;
        if (!phaseloadreg) load_low++;
        if ((!phasestep || !phaseloadreg) && exp_q.size() > 0) begin
          cur = exp_q[0];
          check("strobe_phasesel", 64'(phasesel), 64'(cur.sel));
          check("strobe_phasedir", 64'(phasedir), 64'(cur.dir));
        end
      end
      if (done || aborted) begin
        check("done_aborted_exclusive", 64'(done & aborted), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_completion: done=%0b aborted=%0b with no request pending", done, aborted);
        end else begin
          cur = exp_q.pop_front();
          check("completion_kind_aborted", 64'(aborted), 64'(cur.aborted));
          check("completion_latency", 64'(cyc - acc_cyc), 64'(cur.lat));
          check("phasestep_low_cycles", 64'(step_low), 64'(cur.step_low));
          check("phaseloadreg_low_cycles", 64'(load_low), 64'(cur.load_low));
          for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check($sformatf("rd_pos[%0d]", i), 64'(rd_pos), 64'(cur.pos[i*POS_W +: POS_W]));
          end
        end
        tracking = 0;
        n_done++;
      end
    end
  end

  // Driver tasks
  task automatic handshake(input int sel, input bit dir, input int count, input bit load,
                           output bit ok);
    @(posedge clock);
    #1;
    req_sel   = 2'(sel);
    req_dir   = dir;
    req_count = COUNT_W'(count);
    req_load  = load;
    req_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) @(posedge clock);
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: req_ready=%0b, required 1", req_ready);
    end
  endtask

  // abort_k > 0 drops lock during strobe abort_k (0-based), abort_j cycles into it
  task automatic send(input int sel, input bit dir, input int count, input bit load,
                      input int abort_k, input int abort_j);
    exp_t e;
    int   n;
    int   c;
    int   target;
    bit   ok;
    n = load ? 1 : count;
    c = 0;
    e = '0;
    e.sel = 2'(sel);
    e.dir = dir;
    if (abort_k > 0) begin
      c = S + 1 + abort_k * (P + G) + abort_j;
      e.aborted  = 1'b1;
      e.lat      = 16'(c + 1);
      e.step_low = 16'(abort_k * P + abort_j + 1);
      model_steps(sel, dir, abort_k);
    end else if (!load && count == 0) begin
      e.lat = 16'd1;
    end else begin
      e.lat      = 16'(S + n * (P + G) + 1);
      e.step_low = load ? 16'd0 : 16'(n * P);
      e.load_low = load ? 16'(P) : 16'd0;
      if (load) model_pos[sel] = 0;
      else model_steps(sel, dir, n);
    end
    for (int i = 0; i < 4; i++) e.pos[i*POS_W +: POS_W] = POS_W'(model_pos[i]);
    exp_q.push_back(e);
    target = n_done + 1;
    handshake(sel, dir, count, load, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    if (abort_k > 0) begin
      repeat (c - 1) @(posedge clock);
      #1;
      locked = 1'b0;
    end
    for (int t = 0; t < int'(e.lat) + 100 && n_done < target; t++) @(posedge clock);
    if (n_done < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL completion_timeout: completions=%0d, required %0d", n_done, target);
    end
    if (abort_k > 0) begin
      repeat (3) begin
        @(negedge clock);
        check("req_ready_while_unlocked", 64'(req_ready), 64'd0);
      end
      @(posedge clock);
      #1;
      locked = 1'b1;
    end
  endtask

  task automatic check_reset_values();
    check("rst_phasesel", 64'(phasesel), 64'd0);
    check("rst_phasedir", 64'(phasedir), 64'd0);
    check("rst_phasestep", 64'(phasestep), 64'd1);
    check("rst_phaseloadreg", 64'(phaseloadreg), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("rst_pos[%0d]", i), 64'(rd_pos), 64'd0);
    end
  endtask

  // Main sequence
  initial begin
    bit ok;
    int cnt;
    for (int i = 0; i < 4; i++) model_pos[i] = 0;
    reset_n = 1'b0;
    locked  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    send(2, 1'b0, 3, 1'b0, 0, 0);
    send(2, 1'b1, 5, 1'b0, 0, 0);
    send(1, 1'b0, 0, 1'b0, 0, 0);
    send(2, 1'b0, 7, 1'b1, 0, 0);
    send(1, 1'b0, 4, 1'b0, 1, 1);

    for (int r = 0; r < 16; r++) begin
      cnt = $urandom_range(0, 8);
      if (cnt >= 2 && $urandom_range(0, 3) == 0)
        send($urandom_range(0, 3), 1'($urandom_range(0, 1)), cnt, 1'b0,
             $urandom_range(1, cnt - 1), $urandom_range(0, P - 1));
      else
        send($urandom_range(0, 3), 1'($urandom_range(0, 1)), cnt,
             ($urandom_range(0, 4) == 0), 0, 0);
    end

    send(0, 1'b0, 0, 1'b1, 0, 0);
    send(0, 1'b0, 130, 1'b0, 0, 0);

    handshake(3, 1'b1, 6, 1'b0, ok);
    repeat (12) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset_values();
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_pos[i] = 0;
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_mid_reset", 64'(req_ready), 64'd1);
    send(3, 1'b1, 2, 1'b0, 0, 0);

    repeat (4) @(posedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
